// File: rtl/rgb_light_sequencer.sv
// rgb_light_sequencer
//   Drives a 3*CW-bit RGB light bus from a six-colour sequence. The colour can
//   be stepped by a button (manual), stepped by a free-running period counter
//   (auto), overridden to white, or switched off. Each lit channel is driven
//   at the level given by i_brightness.
//
// Parameters
//   CW          bits per colour channel
//   AUTO_PERIOD clock cycles between colour advances in auto mode (>= 2)
//   FADE_STEP   per-cycle channel step when fading is built in (1 .. 2^CW-1)
//
// Build option
//   RGB_FADE_EN  when defined, each channel ramps toward its target by at most
//                FADE_STEP per cycle instead of jumping to it.
//
// Ports
//   i_clk         system clock, rising edge
//   i_rst         synchronous active-high reset
//   i_mode        00 off, 01 white, 10 manual cycle, 11 auto cycle
//   i_button      synchronous level; a rising edge advances the colour
//   i_brightness  on-level applied to every lit channel
//   o_colour_idx  current colour code 1..6 (bit0 R, bit1 G, bit2 B)
//   o_changed     one-cycle pulse after o_colour_idx updates
//   o_light       registered RGB: red [3CW-1:2CW], green [2CW-1:CW], blue [CW-1:0]
module rgb_light_sequencer #(
    parameter int CW          = 8,
    parameter int AUTO_PERIOD = 50000000,
    parameter int FADE_STEP   = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [1:0]      i_mode,
    input  logic            i_button,
    input  logic [CW-1:0]   i_brightness,
    output logic [2:0]      o_colour_idx,
    output logic            o_changed,
    output logic [3*CW-1:0] o_light
);

    typedef enum logic [1:0] {
        M_OFF    = 2'b00,
        M_WHITE  = 2'b01,
        M_MANUAL = 2'b10,
        M_AUTO   = 2'b11
    } mode_t;

    // Code bits map directly onto channels: bit0 R, bit1 G, bit2 B.
    typedef enum logic [2:0] {
        C_RED     = 3'd1,
        C_GREEN   = 3'd2,
        C_YELLOW  = 3'd3,
        C_BLUE    = 3'd4,
        C_MAGENTA = 3'd5,
        C_CYAN    = 3'd6
    } colour_t;

    localparam int               CNTW     = (AUTO_PERIOD > 2) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [CNTW-1:0]  CNT_LAST = CNTW'(AUTO_PERIOD - 1);

    colour_t                r_colour;
    logic                   r_btn_q;
    logic [CNTW-1:0]        r_cnt;
    logic                   r_changed;
    logic [2:0][CW-1:0]     r_light;   // [2] red, [1] green, [0] blue

    mode_t                  w_mode;
    logic                   w_btn_edge;
    logic                   w_term;
    logic                   w_advance;
    colour_t                w_colour_next;
    logic [2:0][CW-1:0]     w_target;
    logic [2:0][CW-1:0]     w_light_next;

    assign w_mode     = mode_t'(i_mode);
    assign w_btn_edge = i_button & ~r_btn_q;
    assign w_term     = (w_mode == M_AUTO) && (r_cnt == CNT_LAST);

    // A button edge landing on the terminal count still yields one advance.
    assign w_advance  = ((w_mode == M_MANUAL) && w_btn_edge) ||
                        ((w_mode == M_AUTO) && (w_btn_edge || w_term));

    assign w_colour_next = (r_colour == C_CYAN) ? C_RED : colour_t'(r_colour + 3'd1);

    // Per-channel target and next-value logic. Channel ch uses code bit (2-ch).
    for (genvar ch = 0; ch < 3; ch++) begin : g_chan
        always_comb begin
            w_target[ch] = '0;
            case (w_mode)
                M_WHITE:         w_target[ch] = i_brightness;
                M_MANUAL, M_AUTO: if (r_colour[2-ch]) w_target[ch] = i_brightness;
                default:         w_target[ch] = '0;
            endcase
        end

`ifdef RGB_FADE_EN
        localparam logic [CW-1:0] STEP = CW'(FADE_STEP);
        logic [CW-1:0] w_diff;

        // Step toward the target, landing exactly on it when closer than STEP.
        always_comb begin
            w_diff           = '0;
            w_light_next[ch] = r_light[ch];
            if (w_target[ch] > r_light[ch]) begin
                w_diff           = w_target[ch] - r_light[ch];
                w_light_next[ch] = (w_diff > STEP) ? r_light[ch] + STEP : w_target[ch];
            end else if (w_target[ch] < r_light[ch]) begin
                w_diff           = r_light[ch] - w_target[ch];
                w_light_next[ch] = (w_diff > STEP) ? r_light[ch] - STEP : w_target[ch];
            end
        end
`else
        assign w_light_next[ch] = w_target[ch];
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_colour  <= C_RED;
            r_btn_q   <= 1'b0;
            r_cnt     <= '0;
            r_changed <= 1'b0;
            r_light   <= '0;
        end else begin
            // Tracked in every mode so a button held across a mode change
            // does not produce a late edge.
            r_btn_q   <= i_button;
            r_changed <= w_advance;
            r_light   <= w_light_next;
            if (w_advance)
                r_colour <= w_colour_next;
            // Counter only runs in auto mode; any advance restarts the period.
            if ((w_mode == M_AUTO) && !w_advance)
                r_cnt <= r_cnt + 1'b1;
            else
                r_cnt <= '0;
        end
    end

    assign o_colour_idx = r_colour;
    assign o_changed    = r_changed;
    assign o_light      = r_light;

endmodule

// File: tb/tb_rgb_light_sequencer.sv
module tb_rgb_light_sequencer;

    localparam int CW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      mode;
    logic            button;
    logic [CW-1:0]   bri;
    logic [2:0]      idx;
    logic            chg;
    logic [3*CW-1:0] light;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rst;
        logic [1:0]  mode;
        logic        btn;
        logic [7:0]  bri;
        logic [2:0]  e_idx;
        logic        e_chg;
        logic [23:0] e_light;
    } vec_t;

    typedef struct {
        logic [2:0]  idx;
        logic        chg;
        logic [23:0] light;
        int          n;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    rgb_light_sequencer #(.CW(CW), .AUTO_PERIOD(4), .FADE_STEP(16)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_mode       (mode),
        .i_button     (button),
        .i_brightness (bri),
        .o_colour_idx (idx),
        .o_changed    (chg),
        .o_light      (light)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic r, input logic [1:0] m, input logic b,
                                input logic [7:0] br, input logic [2:0] ei,
                                input logic ec, input logic [23:0] el);
        vec_t v;
        v.rst = r; v.mode = m; v.btn = b; v.bri = br;
        v.e_idx = ei; v.e_chg = ec; v.e_light = el;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input int n, input logic [23:0] act,
                         input logic [23:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec %0d: got %h want %h", name, n, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        int   pulses;

        rst = 1'b1; mode = 2'b00; button = 1'b0; bri = '0;

`ifdef RGB_FADE_EN
        add(1, 2'b01, 0, 8'h28, 3'd1, 0, 24'h000000);
        add(0, 2'b01, 0, 8'h28, 3'd1, 0, 24'h101010);
        add(0, 2'b01, 0, 8'h28, 3'd1, 0, 24'h202020);
        add(0, 2'b01, 0, 8'h28, 3'd1, 0, 24'h282828);
        add(0, 2'b01, 0, 8'h28, 3'd1, 0, 24'h282828);
        add(0, 2'b00, 0, 8'h28, 3'd1, 0, 24'h181818);
        add(0, 2'b00, 0, 8'h28, 3'd1, 0, 24'h080808);
        add(0, 2'b00, 0, 8'h28, 3'd1, 0, 24'h000000);
        add(0, 2'b00, 0, 8'h28, 3'd1, 0, 24'h000000);
`else
        // reset, then manual stepping through all six colours
        add(1, 2'b10, 0, 8'hFF, 3'd1, 0, 24'h000000);
        add(0, 2'b10, 0, 8'hFF, 3'd1, 0, 24'hFF0000);
        add(0, 2'b10, 1, 8'hFF, 3'd2, 1, 24'hFF0000);
        add(0, 2'b10, 0, 8'hFF, 3'd2, 0, 24'h00FF00);
        add(0, 2'b10, 1, 8'hFF, 3'd3, 1, 24'h00FF00);
        add(0, 2'b10, 0, 8'hFF, 3'd3, 0, 24'hFFFF00);
        add(0, 2'b10, 1, 8'hFF, 3'd4, 1, 24'hFFFF00);
        add(0, 2'b10, 0, 8'hFF, 3'd4, 0, 24'h0000FF);
        add(0, 2'b10, 1, 8'hFF, 3'd5, 1, 24'h0000FF);
        add(0, 2'b10, 0, 8'hFF, 3'd5, 0, 24'hFF00FF);
        add(0, 2'b10, 1, 8'hFF, 3'd6, 1, 24'hFF00FF);
        add(0, 2'b10, 0, 8'hFF, 3'd6, 0, 24'h00FFFF);
        add(0, 2'b10, 1, 8'hFF, 3'd1, 1, 24'h00FFFF);
        add(0, 2'b10, 0, 8'hFF, 3'd1, 0, 24'hFF0000);
        // button held ten cycles: one advance
        add(0, 2'b10, 1, 8'hFF, 3'd2, 1, 24'hFF0000);
        for (int i = 0; i < 9; i++) add(0, 2'b10, 1, 8'hFF, 3'd2, 0, 24'h00FF00);
        add(0, 2'b10, 0, 8'hFF, 3'd2, 0, 24'h00FF00);
        // auto mode from idx 1
        add(1, 2'b11, 0, 8'hFF, 3'd1, 0, 24'h000000);
        for (int i = 0; i < 3; i++) add(0, 2'b11, 0, 8'hFF, 3'd1, 0, 24'hFF0000);
        add(0, 2'b11, 0, 8'hFF, 3'd2, 1, 24'hFF0000);
        for (int i = 0; i < 3; i++) add(0, 2'b11, 0, 8'hFF, 3'd2, 0, 24'h00FF00);
        add(0, 2'b11, 0, 8'hFF, 3'd3, 1, 24'h00FF00);
        add(0, 2'b11, 0, 8'hFF, 3'd3, 0, 24'hFFFF00);
        // edge on the counter's second cycle: immediate advance
        add(0, 2'b11, 1, 8'hFF, 3'd4, 1, 24'hFFFF00);
        for (int i = 0; i < 3; i++) add(0, 2'b11, 0, 8'hFF, 3'd4, 0, 24'h0000FF);
        add(0, 2'b11, 0, 8'hFF, 3'd5, 1, 24'h0000FF);
        for (int i = 0; i < 3; i++) add(0, 2'b11, 0, 8'hFF, 3'd5, 0, 24'hFF00FF);
        // edge at terminal count: single advance, counter cleared
        add(0, 2'b11, 1, 8'hFF, 3'd6, 1, 24'hFF00FF);
        for (int i = 0; i < 3; i++) add(0, 2'b11, 0, 8'hFF, 3'd6, 0, 24'h00FFFF);
        add(0, 2'b11, 0, 8'hFF, 3'd1, 1, 24'h00FFFF);
        // white mode, button ignored, held across the change back to manual
        add(0, 2'b01, 0, 8'h40, 3'd1, 0, 24'h404040);
        add(0, 2'b01, 1, 8'h40, 3'd1, 0, 24'h404040);
        add(0, 2'b01, 0, 8'h40, 3'd1, 0, 24'h404040);
        add(0, 2'b01, 1, 8'h40, 3'd1, 0, 24'h404040);
        add(0, 2'b10, 1, 8'hFF, 3'd1, 0, 24'hFF0000);
        add(0, 2'b10, 0, 8'hFF, 3'd1, 0, 24'hFF0000);
        // off mode
        add(0, 2'b00, 0, 8'hFF, 3'd1, 0, 24'h000000);
        add(0, 2'b00, 1, 8'hFF, 3'd1, 0, 24'h000000);
        add(0, 2'b00, 0, 8'hFF, 3'd1, 0, 24'h000000);
        // brightness 0: dark but still sequencing
        add(0, 2'b10, 1, 8'h00, 3'd2, 1, 24'h000000);
        add(0, 2'b10, 0, 8'h00, 3'd2, 0, 24'h000000);
        // reach idx 5 in auto, then reset mid-period (with a button edge)
        add(0, 2'b11, 0, 8'hFF, 3'd2, 0, 24'h00FF00);
        add(0, 2'b11, 1, 8'hFF, 3'd3, 1, 24'h00FF00);
        add(0, 2'b11, 0, 8'hFF, 3'd3, 0, 24'hFFFF00);
        add(0, 2'b11, 1, 8'hFF, 3'd4, 1, 24'hFFFF00);
        add(0, 2'b11, 0, 8'hFF, 3'd4, 0, 24'h0000FF);
        add(0, 2'b11, 1, 8'hFF, 3'd5, 1, 24'h0000FF);
        add(0, 2'b11, 0, 8'hFF, 3'd5, 0, 24'hFF00FF);
        add(0, 2'b11, 0, 8'hFF, 3'd5, 0, 24'hFF00FF);
        add(1, 2'b11, 1, 8'hFF, 3'd1, 0, 24'h000000);
        for (int i = 0; i < 3; i++) add(0, 2'b11, 0, 8'hFF, 3'd1, 0, 24'hFF0000);
        add(0, 2'b11, 0, 8'hFF, 3'd2, 1, 24'hFF0000);
`endif

        for (int i = 0; i < tbl.size(); i++) begin
            rst    = tbl[i].rst;
            mode   = tbl[i].mode;
            button = tbl[i].btn;
            bri    = tbl[i].bri;
            sb.push_back(exp_t'{tbl[i].e_idx, tbl[i].e_chg, tbl[i].e_light, i});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check("colour_idx", e.n, {21'd0, idx}, {21'd0, e.idx});
            check("changed",    e.n, {23'd0, chg}, {23'd0, e.chg});
            check("light",      e.n, light, e.light);
        end

`ifndef RGB_FADE_EN
        // Hand sequence: a long held press in manual mode yields exactly one pulse.
        rst = 1'b0; mode = 2'b10; bri = 8'hFF; button = 1'b0;
        @(posedge clk); #1;
        pulses = 0;
        button = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (chg === 1'b1) pulses++;
        end
        button = 1'b0;
        @(posedge clk); #1;
        if (chg === 1'b1) pulses++;
        check("held_pulses", 0, 24'(pulses), 24'd1);
        check("held_idx",    0, {21'd0, idx}, 24'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rgb_light_sequencer.md
Name: rgb_light_sequencer

Overview:
- Parametrised successor of the lights selector.
- Combines button-stepped colour cycling, timed auto-cycling, a white mode and an off mode in one registered block.
- Each colour channel is CW bits wide and scaled by a brightness input.
- Drives the board light bus directly. Replaces the separate cycle, convert and mux stages.

Parameters:
- CW, 8: bits per colour channel; light bus is 3*CW bits.
- AUTO_PERIOD, 50000000: clock cycles between colour advances in auto mode; must be >= 2.
- FADE_STEP, 1: per-cycle channel step when RGB_FADE_EN is defined; must be >= 1 and < 2^CW.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- mode  input  2  00 off, 01 white, 10 manual cycle, 11 auto cycle.
- button  input  1  synchronous level; rising edge advances the colour.
- brightness  input  CW  on-level applied to every lit channel.
- colour_idx  output  3  current colour code, 1..6.
- changed  output  1  one-cycle pulse when colour_idx updates.
- light  output  3*CW  registered RGB: [3*CW-1:2*CW] red, [2*CW-1:CW] green, [CW-1:0] blue.

Behaviour:
- Reset (rst=1 at an edge):
  - colour_idx=1, changed=0, light=0.
  - Auto counter=0; button history register=0.
  - Reset overrides every other event in the same cycle.
- Edge detect: btn_edge = button & ~button_q. button_q is registered every cycle, including in off and white modes, so a button held through a mode change does not fire a late edge.
- Colour sequence: 1→2→3→4→5→6→1.
  - Code bit0=R, bit1=G, bit2=B: 1 red, 2 green, 3 yellow, 4 blue, 5 magenta, 6 cyan.
  - Codes 0 and 7 are never produced.
- Advance rules:
  - Mode 10: advance on btn_edge.
  - Mode 11: counter increments every cycle. At AUTO_PERIOD-1 it wraps to 0 and the colour advances.
  - btn_edge in mode 11: advance immediately and clear the counter.
  - btn_edge coinciding with terminal count: exactly one advance, counter to 0.
  - Modes 00 and 01: colour_idx held, counter held at 0, button edges ignored.
- colour_idx is retained across mode changes.
- changed=1 in the cycle after the edge where colour_idx updated; 0 otherwise.
- Target per channel:
  - mode 00: 0.
  - mode 01: brightness on all three channels.
  - modes 10/11: brightness where the colour_idx bit is set, else 0.
- light <= target each edge, so latency is one cycle:
  - from a mode or brightness change;
  - from a colour_idx update.
  - Button edge sampled at edge k → colour_idx at k → light at k+1.
- brightness=0 gives light=0 in all modes; sequencing continues.

Optional Feature:
- Macro RGB_FADE_EN.
- Defined:
  - Each channel register moves toward its target by min(FADE_STEP, |target-current|) per cycle, with no overshoot and no wrap.
  - Channels fade independently.
  - Reset still forces light=0 immediately.
- Undefined:
  - light jumps to target with one-cycle latency.
  - FADE_STEP is unused.

Test Plan (CW=8, AUTO_PERIOD=4, fade off unless stated):
- Reset, then mode=10, brightness=8'hFF:
  - colour_idx=1, light=24'hFF0000.
  - After one button pulse: colour_idx=2, changed pulses once, light=24'h00FF00 one cycle later.
- Mode=10, six button pulses from idx 1: idx sequence 2,3,4,5,6,1; light for idx 3 is 24'hFFFF00 and for idx 6 is 24'h00FFFF. Button held high 10 cycles gives a single advance.
- Mode=11 from idx 1: idx advances every 4 cycles (1→2→3).
  - Button edge on the counter's 2nd cycle: immediate advance.
  - Next auto advance 4 cycles later.
  - Edge at terminal count: single advance.
- Mode=01, brightness=8'h40: light=24'h404040 one cycle after; colour_idx frozen. Return to mode 10: light shows the retained colour. Mode=00: light=0.
- Assert rst mid-auto-cycle with idx=5: next cycle idx=1, light=0, changed=0, counter restarts from 0.
- RGB_FADE_EN, FADE_STEP=16, mode=01, brightness=8'h28 from light=0:
  - Channels read 16, 32, 40, then stay at 40.
  - Switch to mode 00: 24, 8, 0.
